// File: rtl/hsv_color_match_if.sv
// Pixel stream bundle for hsv_color_match: camera pixels in, tagged pixels out.
interface hsv_color_match_if #(
  parameter int POS_W = 13
);
  logic             in_valid;
  logic [7:0]       in_r;
  logic [7:0]       in_g;
  logic [7:0]       in_b;
  logic [POS_W-1:0] in_row;
  logic [POS_W-1:0] in_col;
  logic             in_eof;
  logic             out_valid;
  logic             out_match;
  logic [POS_W-1:0] out_row;
  logic [POS_W-1:0] out_col;
  logic [7:0]       out_r;
  logic [7:0]       out_g;
  logic [7:0]       out_b;

  modport master (
    output in_valid, in_r, in_g, in_b, in_row, in_col, in_eof,
    input  out_valid, out_match, out_row, out_col, out_r, out_g, out_b
  );

  modport slave (
    input  in_valid, in_r, in_g, in_b, in_row, in_col, in_eof,
    output out_valid, out_match, out_row, out_col, out_r, out_g, out_b
  );
endinterface

// File: rtl/hsv_color_match.sv
// RGB->HSV colour matcher with per-frame match count and bounding box (3-cycle pipeline).
// Optional macro HSV_MATCH_OVERLAY_EN paints matched pixels magenta on the output colour.
module hsv_color_match #(
  parameter int CNT_W = 20,
  parameter int POS_W = 13
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_enable,
  input  logic [13:0]         i_ref_h,
  input  logic [7:0]          i_ref_s,
  input  logic [7:0]          i_ref_v,
  input  logic [9:0]          i_h_tol,
  input  logic [7:0]          i_s_tol,
  input  logic [7:0]          i_v_tol,
  hsv_color_match_if.slave    pix,
  output logic                o_frame_done,
  output logic [CNT_W-1:0]    o_match_count,
  output logic [POS_W-1:0]    o_bbox_rmin,
  output logic [POS_W-1:0]    o_bbox_rmax,
  output logic [POS_W-1:0]    o_bbox_cmin,
  output logic [POS_W-1:0]    o_bbox_cmax,
  output logic                o_bbox_valid
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2} state_t;

  function automatic logic [7:0] max3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] m;
    m = (a >= b) ? a : b;
    return (m >= c) ? m : c;
  endfunction

  function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] m;
    m = (a <= b) ? a : b;
    return (m <= c) ? m : c;
  endfunction

  function automatic logic [14:0] abs15(input logic [14:0] x);
    return x[14] ? (~x + 15'd1) : x;
  endfunction

  state_t           r_state;
  logic             r_v1, r_eof1, r_v2, r_eof2, r_eof3;
  logic [POS_W-1:0] r_row1, r_col1, r_row2, r_col2;
  logic [7:0]       r_r1, r_g1, r_b1, r_max1, r_min1;
  logic [7:0]       r_r2, r_g2, r_b2, r_max2, r_diff2;
  logic [13:0]      r_h2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_any;
  logic [POS_W-1:0] r_rmin, r_rmax, r_cmin, r_cmax;

  logic             w_accept;
  logic [7:0]       w_diff1;
  logic [13:0]      w_h1;
  logic [14:0]      w_dh, w_ds, w_dv;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt_n;
  logic             w_any_n;
  logic [POS_W-1:0] w_rmin_n, w_rmax_n, w_cmin_n, w_cmax_n;

  assign w_accept = pix.in_valid && (r_state == ST_RUN);
  assign w_diff1  = r_max1 - r_min1;

  // Hue with R>G>B tie priority; all terms zero-extended so the 14-bit result wraps correctly negative.
  always_comb begin
    w_h1 = 14'd0;
    if (r_max1 == r_r1) begin
      w_h1 = {6'd0, r_g1} - {6'd0, r_b1};
    end else if (r_max1 == r_g1) begin
      w_h1 = {6'd0, r_b1} - {6'd0, r_r1} + {5'd0, w_diff1, 1'b0};
    end else begin
      w_h1 = {6'd0, r_r1} - {6'd0, r_g1} + {4'd0, w_diff1, 2'b0};
    end
  end

  assign w_dh    = {r_h2[13], r_h2} - {i_ref_h[13], i_ref_h};
  assign w_ds    = {7'd0, r_diff2} - {7'd0, i_ref_s};
  assign w_dv    = {7'd0, r_max2} - {7'd0, i_ref_v};
  assign w_match = r_v2 && (abs15(w_dh) <= {5'd0, i_h_tol}) &&
                   (abs15(w_ds) <= {7'd0, i_s_tol}) && (abs15(w_dv) <= {7'd0, i_v_tol});

  // Next accumulator values, including the pixel about to enter S3.
  always_comb begin
    w_cnt_n  = r_cnt;
    w_any_n  = r_any;
    w_rmin_n = r_rmin;
    w_rmax_n = r_rmax;
    w_cmin_n = r_cmin;
    w_cmax_n = r_cmax;
    if (w_match) begin
      if (r_cnt != {CNT_W{1'b1}}) begin
        w_cnt_n = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        w_cnt_n = r_cnt;
      end
      w_any_n = 1'b1;
      if (!r_any) begin
        w_rmin_n = r_row2;
        w_rmax_n = r_row2;
        w_cmin_n = r_col2;
        w_cmax_n = r_col2;
      end else begin
        w_rmin_n = (r_row2 < r_rmin) ? r_row2 : r_rmin;
        w_rmax_n = (r_row2 > r_rmax) ? r_row2 : r_rmax;
        w_cmin_n = (r_col2 < r_cmin) ? r_col2 : r_cmin;
        w_cmax_n = (r_col2 > r_cmax) ? r_col2 : r_cmax;
      end
    end else begin
      w_any_n = r_any;
    end
  end

  // Frame FSM: enable is only honoured at frame boundaries.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  r_state <= i_enable ? ST_RUN : ST_IDLE;
        ST_RUN:   r_state <= (w_accept && pix.in_eof && !i_enable) ? ST_FLUSH : ST_RUN;
        ST_FLUSH: r_state <= (pix.out_valid && r_eof3) ? ST_IDLE : ST_FLUSH;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Three-stage pixel pipeline.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_v1 <= 1'b0;  r_eof1 <= 1'b0;  r_row1 <= '0;  r_col1 <= '0;
      r_r1 <= 8'd0;  r_g1 <= 8'd0;    r_b1 <= 8'd0;  r_max1 <= 8'd0;  r_min1 <= 8'd0;
      r_v2 <= 1'b0;  r_eof2 <= 1'b0;  r_row2 <= '0;  r_col2 <= '0;
      r_r2 <= 8'd0;  r_g2 <= 8'd0;    r_b2 <= 8'd0;  r_max2 <= 8'd0;  r_diff2 <= 8'd0;
      r_h2 <= 14'd0;
      r_eof3 <= 1'b0;
      pix.out_valid <= 1'b0;  pix.out_match <= 1'b0;
      pix.out_row <= '0;      pix.out_col <= '0;
      pix.out_r <= 8'd0;      pix.out_g <= 8'd0;  pix.out_b <= 8'd0;
    end else begin
      r_v1   <= w_accept;
      r_eof1 <= w_accept && pix.in_eof;
      r_row1 <= pix.in_row;
      r_col1 <= pix.in_col;
      r_r1   <= pix.in_r;
      r_g1   <= pix.in_g;
      r_b1   <= pix.in_b;
      r_max1 <= max3(pix.in_r, pix.in_g, pix.in_b);
      r_min1 <= min3(pix.in_r, pix.in_g, pix.in_b);
      r_v2    <= r_v1;
      r_eof2  <= r_eof1;
      r_row2  <= r_row1;
      r_col2  <= r_col1;
      r_r2    <= r_r1;
      r_g2    <= r_g1;
      r_b2    <= r_b1;
      r_max2  <= r_max1;
      r_diff2 <= w_diff1;
      r_h2    <= w_h1;
      r_eof3        <= r_eof2;
      pix.out_valid <= r_v2;
      pix.out_match <= w_match;
      pix.out_row   <= r_row2;
      pix.out_col   <= r_col2;
`ifdef HSV_MATCH_OVERLAY_EN
      pix.out_r <= w_match ? 8'hFF : r_r2;
      pix.out_g <= w_match ? 8'h00 : r_g2;
      pix.out_b <= w_match ? 8'hFF : r_b2;
`else
      pix.out_r <= r_r2;
      pix.out_g <= r_g2;
      pix.out_b <= r_b2;
`endif
    end
  end

  // Frame statistics: publish alongside the eof pixel's out_valid, then restart.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;  r_any <= 1'b0;
      r_rmin <= '0; r_rmax <= '0; r_cmin <= '0; r_cmax <= '0;
      o_frame_done <= 1'b0;  o_match_count <= '0;  o_bbox_valid <= 1'b0;
      o_bbox_rmin <= '0; o_bbox_rmax <= '0; o_bbox_cmin <= '0; o_bbox_cmax <= '0;
    end else if (r_v2 && r_eof2) begin
      o_frame_done  <= 1'b1;
      o_match_count <= w_cnt_n;
      o_bbox_valid  <= w_any_n;
      o_bbox_rmin   <= w_rmin_n;
      o_bbox_rmax   <= w_rmax_n;
      o_bbox_cmin   <= w_cmin_n;
      o_bbox_cmax   <= w_cmax_n;
      r_cnt <= '0;  r_any <= 1'b0;
      r_rmin <= '0; r_rmax <= '0; r_cmin <= '0; r_cmax <= '0;
    end else begin
      o_frame_done <= 1'b0;
      r_cnt  <= w_cnt_n;
      r_any  <= w_any_n;
      r_rmin <= w_rmin_n;
      r_rmax <= w_rmax_n;
      r_cmin <= w_cmin_n;
      r_cmax <= w_cmax_n;
    end
  end

endmodule

// File: tb/tb_hsv_color_match.sv
// Randomized scoreboard bench for hsv_color_match against a plain-arithmetic HSV/frame model.
module tb_hsv_color_match;
  localparam int CNT_W = 20;
  localparam int POS_W = 13;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic [13:0]      ref_h = 14'd0;
  logic [7:0]       ref_s = 8'd0, ref_v = 8'd0, s_tol = 8'd0, v_tol = 8'd0;
  logic [9:0]       h_tol = 10'd0;
  logic             frame_done, bbox_valid;
  logic [CNT_W-1:0] match_count;
  logic [POS_W-1:0] bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax;

  hsv_color_match_if #(.POS_W(POS_W)) pif ();

  hsv_color_match #(.CNT_W(CNT_W), .POS_W(POS_W)) dut (
    .clk(clk), .reset_n(reset_n), .i_enable(enable),
    .i_ref_h(ref_h), .i_ref_s(ref_s), .i_ref_v(ref_v),
    .i_h_tol(h_tol), .i_s_tol(s_tol), .i_v_tol(v_tol),
    .pix(pif),
    .o_frame_done(frame_done), .o_match_count(match_count),
    .o_bbox_rmin(bbox_rmin), .o_bbox_rmax(bbox_rmax),
    .o_bbox_cmin(bbox_cmin), .o_bbox_cmax(bbox_cmax),
    .o_bbox_valid(bbox_valid)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int row; int col; int r; int g; int b; bit match; bit eof; int unsigned issue;} pix_t;
  typedef struct {int cnt; int rmin; int rmax; int cmin; int cmax; bit any;} frm_t;

  pix_t pixq[$];
  frm_t frmq[$];
  frm_t acc;
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_ref_h, m_ref_s, m_ref_v, m_htol, m_stol, m_vtol;
  int   base_r, base_g, base_b;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void hsv(input int r, input int g, input int b, output int h, output int s, output int v);
    int mx, mn;
    mx = (r > g) ? r : g;  mx = (mx > b) ? mx : b;
    mn = (r < g) ? r : g;  mn = (mn < b) ? mn : b;
    s = mx - mn;
    v = mx;
    if (r == mx)      h = g - b;
    else if (g == mx) h = (b - r) + 2 * s;
    else              h = (r - g) + 4 * s;
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic bit model_match(input int r, input int g, input int b);
    int h, s, v;
    hsv(r, g, b, h, s, v);
    return (iabs(h - m_ref_h) <= m_htol) && (iabs(s - m_ref_s) <= m_stol) && (iabs(v - m_ref_v) <= m_vtol);
  endfunction

  function automatic int clamp8(input int x);
    return (x < 0) ? 0 : ((x > 255) ? 255 : x);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    pif.in_valid = 1'b0;
    pif.in_eof   = 1'b0;
    repeat (n) tick();
  endtask

  task automatic set_ref(input int h, input int s, input int v, input int ht, input int st, input int vt);
    m_ref_h = h; m_ref_s = s; m_ref_v = v; m_htol = ht; m_stol = st; m_vtol = vt;
    ref_h = 14'(h); ref_s = 8'(s); ref_v = 8'(v);
    h_tol = 10'(ht); s_tol = 8'(st); v_tol = 8'(vt);
  endtask

  task automatic set_random_ref();
    int h, s, v;
    base_r = $urandom_range(0, 255);
    base_g = $urandom_range(0, 255);
    base_b = $urandom_range(0, 255);
    hsv(base_r, base_g, base_b, h, s, v);
    set_ref(h, s, v, $urandom_range(0, 24), $urandom_range(0, 8), $urandom_range(0, 8));
  endtask

  // Pixel that the DUT is expected to accept; records the expected output and frame stats.
  task automatic drive_px(input int row, input int col, input int r, input int g, input int b, input bit eof);
    pix_t e;
    pif.in_valid = 1'b1;
    pif.in_row = POS_W'(row); pif.in_col = POS_W'(col);
    pif.in_r = 8'(r); pif.in_g = 8'(g); pif.in_b = 8'(b);
    pif.in_eof = eof;
    e = '{row: row, col: col, r: r, g: g, b: b, match: model_match(r, g, b), eof: eof, issue: cyc};
    pixq.push_back(e);
    if (e.match) begin
      if (!acc.any) acc = '{cnt: 0, rmin: row, rmax: row, cmin: col, cmax: col, any: 1'b1};
      acc.cnt++;
      if (row < acc.rmin) acc.rmin = row;
      if (row > acc.rmax) acc.rmax = row;
      if (col < acc.cmin) acc.cmin = col;
      if (col > acc.cmax) acc.cmax = col;
    end
    if (eof) begin
      frmq.push_back(acc);
      acc = '{default: 0};
    end
    tick();
  endtask

  // Pixels offered while the block is not running: nothing may come out for them.
  task automatic junk(input int n);
    for (int i = 0; i < n; i++) begin
      pif.in_valid = 1'b1;
      pif.in_row = POS_W'($urandom_range(0, 100)); pif.in_col = POS_W'($urandom_range(0, 100));
      pif.in_r = 8'($urandom); pif.in_g = 8'($urandom); pif.in_b = 8'($urandom);
      pif.in_eof = 1'($urandom);
      tick();
    end
    idle_cycles(1);
  endtask

  // kind 0: near/far random around the reference colour, 1: directed 4x4 scene, 2: gray only.
  task automatic send_frame(input int rows, input int cols, input int kind, input int drop_at, input int abort_at);
    int idx, r, g, b;
    idx = 0;
    for (int row = 0; row < rows; row++) begin
      for (int col = 0; col < cols; col++) begin
        if (idx == abort_at) return;
        if (idx == drop_at) enable = 1'b0;
        if (kind == 1) begin
          if (row == 1 && col == 2)      begin r = 200; g = 40;  b = 40; end
          else if (row == 3 && col == 0) begin r = 200; g = 50;  b = 40; end
          else if (row == 0 && col == 1) begin r = 200; g = 51;  b = 40; end
          else if (row == 0 && col == 0) begin r = 40;  g = 200; b = 40; end
          else                           begin r = 100; g = 100; b = 100; end
        end else if (kind == 2) begin
          r = $urandom_range(0, 255); g = r; b = r;
        end else if ($urandom_range(0, 1) == 1) begin
          r = clamp8(base_r + $urandom_range(0, 6) - 3);
          g = clamp8(base_g + $urandom_range(0, 6) - 3);
          b = clamp8(base_b + $urandom_range(0, 6) - 3);
        end else begin
          r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
        end
        drive_px(row, col, r, g, b, (row == rows - 1) && (col == cols - 1));
        idx++;
      end
    end
    pif.in_valid = 1'b0;
    pif.in_eof   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pix_ctl"}, {pif.out_valid, pif.out_match, pif.out_row, pif.out_col}, 0);
    chk({tag, "_pix_rgb"}, {pif.out_r, pif.out_g, pif.out_b}, 0);
    chk({tag, "_stats"}, {frame_done, bbox_valid, match_count}, 0);
    chk({tag, "_bbox"}, {bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax}, 0);
  endtask

  task automatic restart_after_drop();
    idle_cycles(8);
    junk(5);
    enable = 1'b1;
    idle_cycles(2);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pixel.
  always @(negedge clk) begin : mon
    pix_t   e;
    frm_t   f;
    longint exp_rgb;
    if (reset_n) begin
      if (pif.out_valid) begin
        if (pixq.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = pixq.pop_front();
          exp_rgb = {8'(e.r), 8'(e.g), 8'(e.b)};
`ifdef HSV_MATCH_OVERLAY_EN
          if (e.match) exp_rgb = 24'hFF00FF;
`endif
          chk("latency", cyc - e.issue, 3);
          chk("row_col", {pif.out_row, pif.out_col}, {POS_W'(e.row), POS_W'(e.col)});
          chk("colour", {pif.out_r, pif.out_g, pif.out_b}, exp_rgb);
          chk("match", pif.out_match, e.match);
          chk("frame_done", frame_done, e.eof);
          if (e.eof) begin
            if (frmq.size() == 0) begin
              chk("frame_stats_missing", 1, 0);
            end else begin
              f = frmq.pop_front();
              chk("match_count", match_count, f.cnt);
              chk("bbox_valid", bbox_valid, f.any);
              chk("bbox", {bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax},
                  {POS_W'(f.rmin), POS_W'(f.rmax), POS_W'(f.cmin), POS_W'(f.cmax)});
            end
          end
        end
      end else if (frame_done) begin
        chk("frame_done_without_pixel", 1, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    acc = '{default: 0};
    pif.in_valid = 1'b0; pif.in_eof = 1'b0;
    pif.in_row = '0; pif.in_col = '0;
    pif.in_r = 8'd0; pif.in_g = 8'd0; pif.in_b = 8'd0;
    repeat (3) tick();
    check_zero("reset");
    reset_n = 1'b1;
    tick();
    junk(4);
    enable = 1'b1;
    idle_cycles(2);

    set_ref(0, 160, 200, 10, 0, 0);
    send_frame(4, 4, 1, -1, -1);
    idle_cycles(4);
    set_ref(0, 160, 200, 0, 0, 0);
    send_frame(3, 5, 2, 5, -1);
    restart_after_drop();

    for (int i = 0; i < 10; i++) begin
      idle_cycles(4);
      set_random_ref();
      if (i % 3 == 2) begin
        send_frame($urandom_range(2, 6), $urandom_range(3, 8), 0, $urandom_range(0, 5), -1);
        restart_after_drop();
      end else begin
        send_frame($urandom_range(2, 6), $urandom_range(3, 8), 0, -1, -1);
      end
    end

    idle_cycles(4);
    set_random_ref();
    send_frame(4, 6, 0, -1, 10);
    reset_n = 1'b0;
    pif.in_valid = 1'b0;
    tick();
    check_zero("midreset");
    pixq.delete();
    frmq.delete();
    acc = '{default: 0};
    reset_n = 1'b1;
    idle_cycles(2);
    send_frame(4, 5, 0, -1, -1);

    idle_cycles(10);
    chk("pixel_queue_drained", pixq.size(), 0);
    chk("frame_queue_drained", frmq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
